pid_error_calc: RTL and testbench
=================================

Name: pid_error_calc

Overview:
- Upstream neighbour of the PID mixer: turns attitude setpoints and measured attitude into the P/I/D error terms per axis (pitch, roll, yaw).
- Issues a one-cycle cal_pid_en strobe when all nine terms are stable.
- Sample-driven, not free-running: one computation per angle_valid pulse from the attitude estimator.
- All angle quantities are 24-bit two's-complement, in 0.01 degree units.

Parameters:
- I_LIMIT, 24'd500000, symmetric clamp on each integral accumulator (±I_LIMIT).
- D_SHIFT, 0, arithmetic right shift applied to the raw derivative, range 0–7.
- YAW_HALF_TURN, 24'd18000, half-turn in angle units; used only under the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- angle_valid  in  1  one-cycle strobe; meas_* and tgt_* are valid this cycle
- arm  in  1  level; 0 holds integrators and derivative history cleared
- tgt_pitch, tgt_roll, tgt_yaw  in  24 each  setpoints, signed
- meas_pitch, meas_roll, meas_yaw  in  24 each  measured angles, signed
- pitch_error, roll_error, yaw_error  out  24 each  P terms, signed
- i_pitch_error, i_roll_error, i_yaw_error  out  24 each  I terms, signed
- d_pitch_error, d_roll_error, d_yaw_error  out  24 each  D terms, signed
- cal_pid_en  out  1  one-cycle strobe; all nine outputs valid
- busy  out  1  high while a sample is being processed
- overrun  out  1  one-cycle pulse when an angle_valid is dropped

Behaviour:
- Reset (async, rst_n=0): every output is 0, FSM goes to IDLE, integrators are 0, previous-error registers are 0, first_sample=1.
- FSM states and transitions:
  - IDLE: on angle_valid, capture all six inputs into registers and go to ERR.
  - ERR: e = tgt − meas, computed per axis at 25 bits, then saturated to 24-bit signed (0x7FFFFF / 0x800000). Go to ACC.
  - ACC:
    - Integral: i_new = clamp(i_acc + e, −I_LIMIT, +I_LIMIT), computed at 25 bits before the clamp.
    - Derivative: d = sat24((e − e_prev) >>> D_SHIFT); forced to 0 when first_sample=1.
    - Then e_prev ← e and first_sample ← 0. Go to OUT.
  - OUT: load all nine output registers, pulse cal_pid_en for exactly one cycle, return to IDLE.
- Latency: angle_valid at cycle N gives cal_pid_en at cycle N+3.
- Outputs hold their values between strobes.
- busy is high in ERR, ACC and OUT.
- angle_valid while busy: the sample is dropped and overrun pulses the next cycle. The sample in flight is unaffected. Maximum sample rate is one per 3 cycles; angle_valid in the same cycle that OUT returns to IDLE is accepted.
- arm=0:
  - Integrators are cleared and first_sample is set every cycle.
  - The P path still runs. I outputs are 0 and D outputs are 0.
  - When arm=0 coincides with ACC, clearing wins: that pass gives i=0 and d=0.
- arm rising: the first armed sample has d=0 and the integral starts from e.
- Reset mid-computation: the FSM returns to IDLE immediately and no cal_pid_en is issued.
- Saturation order is fixed: subtract, then saturate e; accumulate, then clamp i; difference, then shift, then saturate d.

Optional Feature:
- Macro: PID_YAW_WRAP_EN.
- When defined, yaw error is wrapped into [−YAW_HALF_TURN, +YAW_HALF_TURN) after subtraction and before saturation:
  - if e ≥ YAW_HALF_TURN, subtract 2·YAW_HALF_TURN;
  - if e < −YAW_HALF_TURN, add 2·YAW_HALF_TURN;
  - this wrap is a single correction step.
- The yaw derivative difference is wrapped by the same rule.
- When undefined, yaw is treated exactly like pitch and roll (plain saturation).

Decomposition:
- Shared package pid_pkg holds:
  - ANGLE_W = 24;
  - the FSM state encoding (IDLE, ERR, ACC, OUT);
  - sat24 and clamp helper functions;
  - the default I_LIMIT and YAW_HALF_TURN constants, reused by the mixer.
- One sub-module, pid_axis_term, instantiated three times:
  - holds one axis's e_prev, i_acc and first_sample;
  - computes e, i and d;
  - yaw instance carries a WRAP parameter driven by the macro.
- The top level owns the FSM, input capture, strobes and overrun.

Test Plan:
- Single sample: reset, arm=1, tgt_pitch=1000, meas_pitch=400, angle_valid → cal_pid_en 3 cycles later, pitch_error=600, i_pitch_error=600, d_pitch_error=0.
- Second sample: tgt_pitch=1000, meas_pitch=700 → pitch_error=300, i_pitch_error=900, d_pitch_error=−300.
- Integral clamp: repeat error 400000 → i_* outputs 400000, then 500000, and stay 500000.
- Error saturation: tgt=0x7FFFFF, meas=0x800000 → error 0x7FFFFF.
- Overrun: angle_valid on two consecutive cycles → one cal_pid_en, overrun pulse, outputs from the first sample only.
- Disarm and wrap: arm=0 mid-stream → i=0 and d=0. Then with PID_YAW_WRAP_EN, tgt_yaw=17900, meas_yaw=−17900 → yaw_error=−200; without the macro → yaw_error=35800.

Source files
------------

// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared widths, FSM encoding and saturation helpers for the PID error path
package pid_pkg;

    localparam int ANGLE_W = 24;

    localparam logic [ANGLE_W-1:0] I_LIMIT_DEF       = 24'd500000;
    localparam logic [ANGLE_W-1:0] YAW_HALF_TURN_DEF = 24'd18000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR  = 2'd1,
        ACC  = 2'd2,
        OUT  = 2'd3
    } pid_state_e;

    function automatic logic signed [ANGLE_W-1:0] sat24(input logic signed [ANGLE_W:0] v);
        if (v > 25'sh07FFFFF) begin
            return 24'sh7FFFFF;
        end else if (v < -25'sh0800000) begin
            return 24'sh800000;
        end
        return v[ANGLE_W-1:0];
    endfunction

    function automatic logic signed [ANGLE_W-1:0] clamp(input logic signed [ANGLE_W:0] v,
                                                        input logic [ANGLE_W-1:0] lim);
        logic signed [ANGLE_W:0] hi;
        logic signed [ANGLE_W:0] lo;
        hi = $signed({1'b0, lim});
        lo = -hi;
        if (v > hi) begin
            return hi[ANGLE_W-1:0];
        end else if (v < lo) begin
            return lo[ANGLE_W-1:0];
        end
        return v[ANGLE_W-1:0];
    endfunction

    // Single correction step into [-half, +half); result still needs sat24.
    function automatic logic signed [ANGLE_W:0] wrap(input logic signed [ANGLE_W:0] v,
                                                     input logic [ANGLE_W-1:0] half);
        logic signed [ANGLE_W+1:0] x;
        logic signed [ANGLE_W+1:0] h;
        x = $signed({v[ANGLE_W], v});
        h = $signed({2'b00, half});
        if (x >= h) begin
            x = x - (h <<< 1);
        end else if (x < -h) begin
            x = x + (h <<< 1);
        end
        return x[ANGLE_W:0];
    endfunction

endpackage

// File: rtl/pid_axis_term.sv
// rtl/pid_axis_term.sv - one axis: P error, clamped integral and shifted derivative
module pid_axis_term
    import pid_pkg::*;
#(
    parameter logic [ANGLE_W-1:0] I_LIMIT   = I_LIMIT_DEF,
    parameter int unsigned        D_SHIFT   = 0,
    parameter logic [ANGLE_W-1:0] HALF_TURN = YAW_HALF_TURN_DEF,
    parameter bit                 WRAP      = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      arm_i,
    input  logic                      err_en_i,
    input  logic                      acc_en_i,
    input  logic signed [ANGLE_W-1:0] tgt_i,
    input  logic signed [ANGLE_W-1:0] meas_i,
    output logic signed [ANGLE_W-1:0] e_o,
    output logic signed [ANGLE_W-1:0] i_o,
    output logic signed [ANGLE_W-1:0] d_o
);

    logic signed [ANGLE_W-1:0] e_q;
    logic signed [ANGLE_W-1:0] e_d;
    logic signed [ANGLE_W-1:0] e_prev_q;
    logic signed [ANGLE_W-1:0] i_acc_q;
    logic                      first_q;
    logic signed [ANGLE_W:0]   e_raw;
    logic signed [ANGLE_W:0]   i_sum;
    logic signed [ANGLE_W:0]   d_raw;
    logic signed [ANGLE_W:0]   d_sh;

    always_comb begin
        e_raw = $signed({tgt_i[ANGLE_W-1], tgt_i}) - $signed({meas_i[ANGLE_W-1], meas_i});
        if (WRAP) begin
            e_raw = wrap(e_raw, HALF_TURN);
        end
        e_d = sat24(e_raw);

        i_sum = $signed({i_acc_q[ANGLE_W-1], i_acc_q}) + $signed({e_q[ANGLE_W-1], e_q});
        d_raw = $signed({e_q[ANGLE_W-1], e_q}) - $signed({e_prev_q[ANGLE_W-1], e_prev_q});
        if (WRAP) begin
            d_raw = wrap(d_raw, HALF_TURN);
        end
        d_sh = d_raw >>> D_SHIFT;

        // Disarm overrides the ACC pass, so both terms collapse to zero.
        i_o = arm_i ? clamp(i_sum, I_LIMIT) : '0;
        d_o = (arm_i && !first_q) ? sat24(d_sh) : '0;
    end

    assign e_o = e_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q      <= '0;
            e_prev_q <= '0;
            i_acc_q  <= '0;
            first_q  <= 1'b1;
        end else begin
            if (err_en_i) begin
                e_q <= e_d;
            end
            if (acc_en_i) begin
                e_prev_q <= e_q;
            end
            if (!arm_i) begin
                i_acc_q <= '0;
                first_q <= 1'b1;
            end else if (acc_en_i) begin
                i_acc_q <= i_o;
                first_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pid_error_calc.sv
// rtl/pid_error_calc.sv - per-sample P/I/D error FSM for three axes; PID_YAW_WRAP_EN enables yaw wrap
module pid_error_calc
    import pid_pkg::*;
#(
    parameter logic [ANGLE_W-1:0] I_LIMIT       = I_LIMIT_DEF,
    parameter int unsigned        D_SHIFT       = 0,
    parameter logic [ANGLE_W-1:0] YAW_HALF_TURN = YAW_HALF_TURN_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      angle_valid,
    input  logic                      arm,
    input  logic signed [ANGLE_W-1:0] tgt_pitch,
    input  logic signed [ANGLE_W-1:0] tgt_roll,
    input  logic signed [ANGLE_W-1:0] tgt_yaw,
    input  logic signed [ANGLE_W-1:0] meas_pitch,
    input  logic signed [ANGLE_W-1:0] meas_roll,
    input  logic signed [ANGLE_W-1:0] meas_yaw,
    output logic signed [ANGLE_W-1:0] pitch_error,
    output logic signed [ANGLE_W-1:0] roll_error,
    output logic signed [ANGLE_W-1:0] yaw_error,
    output logic signed [ANGLE_W-1:0] i_pitch_error,
    output logic signed [ANGLE_W-1:0] i_roll_error,
    output logic signed [ANGLE_W-1:0] i_yaw_error,
    output logic signed [ANGLE_W-1:0] d_pitch_error,
    output logic signed [ANGLE_W-1:0] d_roll_error,
    output logic signed [ANGLE_W-1:0] d_yaw_error,
    output logic                      cal_pid_en,
    output logic                      busy,
    output logic                      overrun
);

`ifdef PID_YAW_WRAP_EN
    localparam bit YAW_WRAP = 1'b1;
`else
    localparam bit YAW_WRAP = 1'b0;
`endif

    pid_state_e state_q, state_d;
    logic [2:0][ANGLE_W-1:0] tgt_q, meas_q;
    logic [2:0][ANGLE_W-1:0] e_w, i_w, d_w;
    logic [2:0][ANGLE_W-1:0] e_out_q, i_out_q, d_out_q;
    logic                    cal_q, ovr_q, accept, err_en, acc_en;

    assign err_en = (state_q == ERR);
    assign acc_en = (state_q == ACC);

    // OUT also accepts a new sample so the pipeline sustains one sample per 3 cycles.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, OUT: begin
                state_d = IDLE;
                if (angle_valid) begin
                    accept  = 1'b1;
                    state_d = ERR;
                end
            end
            ERR:     state_d = ACC;
            ACC:     state_d = OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            meas_q  <= '0;
            e_out_q <= '0;
            i_out_q <= '0;
            d_out_q <= '0;
            cal_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cal_q   <= acc_en;
            ovr_q   <= angle_valid && (err_en || acc_en);
            if (accept) begin
                tgt_q  <= {tgt_yaw, tgt_roll, tgt_pitch};
                meas_q <= {meas_yaw, meas_roll, meas_pitch};
            end
            if (acc_en) begin
                e_out_q <= e_w;
                i_out_q <= i_w;
                d_out_q <= d_w;
            end
        end
    end

    for (genvar ax = 0; ax < 3; ax++) begin : g_axis
        pid_axis_term #(
            .I_LIMIT   (I_LIMIT),
            .D_SHIFT   (D_SHIFT),
            .HALF_TURN (YAW_HALF_TURN),
            .WRAP      ((ax == 2) && YAW_WRAP)
        ) u_term (
            .clk      (clk),
            .rst_n    (rst_n),
            .arm_i    (arm),
            .err_en_i (err_en),
            .acc_en_i (acc_en),
            .tgt_i    (tgt_q[ax]),
            .meas_i   (meas_q[ax]),
            .e_o      (e_w[ax]),
            .i_o      (i_w[ax]),
            .d_o      (d_w[ax])
        );
    end

    assign pitch_error   = e_out_q[0];
    assign roll_error    = e_out_q[1];
    assign yaw_error     = e_out_q[2];
    assign i_pitch_error = i_out_q[0];
    assign i_roll_error  = i_out_q[1];
    assign i_yaw_error   = i_out_q[2];
    assign d_pitch_error = d_out_q[0];
    assign d_roll_error  = d_out_q[1];
    assign d_yaw_error   = d_out_q[2];
    assign cal_pid_en    = cal_q;
    assign overrun       = ovr_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_pid_error_calc.sv
// tb/tb_pid_error_calc.sv - directed vectors against a sample-level model of pid_error_calc
module tb_pid_error_calc;

    localparam int     D_SHIFT = 0;
    localparam longint ILIM    = 500000;
    localparam longint HALF    = 18000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic angle_valid = 1'b0;
    logic arm = 1'b0;
    logic signed [23:0] tgt_pitch = '0, tgt_roll = '0, tgt_yaw = '0;
    logic signed [23:0] meas_pitch = '0, meas_roll = '0, meas_yaw = '0;
    logic signed [23:0] pitch_error, roll_error, yaw_error;
    logic signed [23:0] i_pitch_error, i_roll_error, i_yaw_error;
    logic signed [23:0] d_pitch_error, d_roll_error, d_yaw_error;
    logic cal_pid_en, busy, overrun;

    pid_error_calc #(
        .I_LIMIT       (24'd500000),
        .D_SHIFT       (D_SHIFT),
        .YAW_HALF_TURN (24'd18000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .angle_valid   (angle_valid),
        .arm           (arm),
        .tgt_pitch     (tgt_pitch),
        .tgt_roll      (tgt_roll),
        .tgt_yaw       (tgt_yaw),
        .meas_pitch    (meas_pitch),
        .meas_roll     (meas_roll),
        .meas_yaw      (meas_yaw),
        .pitch_error   (pitch_error),
        .roll_error    (roll_error),
        .yaw_error     (yaw_error),
        .i_pitch_error (i_pitch_error),
        .i_roll_error  (i_roll_error),
        .i_yaw_error   (i_yaw_error),
        .d_pitch_error (d_pitch_error),
        .d_roll_error  (d_roll_error),
        .d_yaw_error   (d_yaw_error),
        .cal_pid_en    (cal_pid_en),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]      due;
        logic [8:0][23:0] v;
    } exp_t;

    exp_t             exp_q[$];
    int               ovr_q[$];
    logic [8:0][23:0] held;
    logic [8:0][23:0] act;
    longint           ia[3];
    longint           ep[3];
    bit               first[3];
    int               last_acc;
    bit               arm_plan;
    int               checks = 0;
    int               errors = 0;
    string            oname[9] = '{"pitch_error", "roll_error", "yaw_error",
                                   "i_pitch_error", "i_roll_error", "i_yaw_error",
                                   "d_pitch_error", "d_roll_error", "d_yaw_error"};

    assign act = {d_yaw_error, d_roll_error, d_pitch_error,
                  i_yaw_error, i_roll_error, i_pitch_error,
                  yaw_error, roll_error, pitch_error};

`ifdef PID_YAW_WRAP_EN
    localparam bit YAW_WRAP = 1'b1;
`else
    localparam bit YAW_WRAP = 1'b0;
`endif

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, want);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 8388607) return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    function automatic longint wrapv(input longint v);
        if (v >= HALF) return v - 2 * HALF;
        if (v < -HALF) return v + 2 * HALF;
        return v;
    endfunction

    function automatic longint lim(input longint v);
        if (v > ILIM) return ILIM;
        if (v < -ILIM) return -ILIM;
        return v;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        ovr_q.delete();
        held = '0;
        last_acc = -100;
        for (int k = 0; k < 3; k++) begin
            ia[k] = 0;
            ep[k] = 0;
            first[k] = 1'b1;
        end
    endtask

    // Applies one sample at the next falling edge and predicts its outcome.
    task automatic send(input longint tp, input longint mp, input longint tr,
                        input longint mr, input longint ty, input longint my);
        longint t[3];
        longint m[3];
        longint e, i, d, diff;
        exp_t   x;
        @(negedge clk);
        tgt_pitch = 24'(tp); meas_pitch = 24'(mp);
        tgt_roll  = 24'(tr); meas_roll  = 24'(mr);
        tgt_yaw   = 24'(ty); meas_yaw   = 24'(my);
        angle_valid = 1'b1;
        t = '{tp, tr, ty};
        m = '{mp, mr, my};
        if (cyc >= last_acc + 3) begin
            last_acc = cyc;
            x.due = 32'(cyc + 3);
            for (int ax = 0; ax < 3; ax++) begin
                e = t[ax] - m[ax];
                if (ax == 2 && YAW_WRAP) e = wrapv(e);
                e = sat(e);
                if (arm_plan) begin
                    i = lim(ia[ax] + e);
                    diff = e - ep[ax];
                    if (ax == 2 && YAW_WRAP) diff = wrapv(diff);
                    d = first[ax] ? 0 : sat(diff >>> D_SHIFT);
                    ia[ax] = i;
                    ep[ax] = e;
                    first[ax] = 1'b0;
                end else begin
                    i = 0;
                    d = 0;
                    ia[ax] = 0;
                    first[ax] = 1'b1;
                end
                x.v[ax]     = 24'(e);
                x.v[3 + ax] = 24'(i);
                x.v[6 + ax] = 24'(d);
            end
            exp_q.push_back(x);
        end else begin
            ovr_q.push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            angle_valid = 1'b0;
        end
    endtask

    task automatic set_arm(input bit v);
        @(negedge clk);
        angle_valid = 1'b0;
        arm = v;
        arm_plan = v;
        if (!v) begin
            for (int k = 0; k < 3; k++) begin
                ia[k] = 0;
                first[k] = 1'b1;
            end
        end
    endtask

    // Per-cycle comparison, sampled 1 time unit after the rising edge.
    bit exp_cal, exp_ovr, exp_busy;
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            exp_cal = (exp_q.size() > 0) && (exp_q[0].due == 32'(cyc));
            exp_ovr = (ovr_q.size() > 0) && (ovr_q[0] == cyc);
            exp_busy = (cyc >= last_acc + 1) && (cyc <= last_acc + 3);
            chk("cal_pid_en", longint'(cal_pid_en), longint'(exp_cal));
            chk("overrun", longint'(overrun), longint'(exp_ovr));
            chk("busy", longint'(busy), longint'(exp_busy));
            if (exp_ovr) void'(ovr_q.pop_front());
            if (exp_cal) begin
                held = exp_q[0].v;
                void'(exp_q.pop_front());
            end
            for (int k = 0; k < 9; k++) begin
                chk(oname[k], longint'($signed(act[k])), longint'($signed(held[k])));
            end
        end
    end

    initial begin
        model_reset();
        arm = 1'b1;
        arm_plan = 1'b1;
        #1;
        chk("reset_pitch_error", longint'(pitch_error), 0);
        chk("reset_i_roll_error", longint'(i_roll_error), 0);
        chk("reset_d_yaw_error", longint'(d_yaw_error), 0);
        chk("reset_cal_pid_en", longint'(cal_pid_en), 0);
        chk("reset_busy", longint'(busy), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        send(1000, 400, 0, 0, 0, 0);
        idle(5);
        chk("lit1_pitch", longint'(pitch_error), 600);
        chk("lit1_i_pitch", longint'(i_pitch_error), 600);
        chk("lit1_d_pitch", longint'(d_pitch_error), 0);

        send(1000, 700, 0, 0, 0, 0);
        idle(5);
        chk("lit2_pitch", longint'(pitch_error), 300);
        chk("lit2_i_pitch", longint'(i_pitch_error), 900);
        chk("lit2_d_pitch", longint'(d_pitch_error), -300);

        set_arm(1'b0);
        idle(2);
        set_arm(1'b1);
        send(0, 0, 400000, 0, 0, 0);
        idle(4);
        chk("clamp1_i_roll", longint'(i_roll_error), 400000);
        chk("clamp1_d_roll", longint'(d_roll_error), 0);
        send(0, 0, 400000, 0, 0, 0);
        idle(4);
        chk("clamp2_i_roll", longint'(i_roll_error), 500000);
        send(0, 0, 400000, 0, 0, 0);
        idle(4);
        chk("clamp3_i_roll", longint'(i_roll_error), 500000);

        send(8388607, -8388608, -8388608, 8388607, 0, 0);
        idle(4);
        chk("sat_pitch", longint'(pitch_error), 8388607);
        chk("sat_roll", longint'(roll_error), -8388608);
        chk("sat_i_roll", longint'(i_roll_error), -500000);

        send(100, 0, 0, 0, 0, 0);
        send(900, 0, 0, 0, 0, 0);
        idle(5);
        chk("ovr_pitch", longint'(pitch_error), 100);

        send(50, 0, 0, 0, 0, 0);
        idle(2);
        send(70, 0, 0, 0, 0, 0);
        idle(5);
        chk("rate_pitch", longint'(pitch_error), 70);
        chk("rate_d_pitch", longint'(d_pitch_error), 20);

        set_arm(1'b0);
        send(500, 100, 0, 0, 0, 0);
        idle(4);
        chk("disarm_pitch", longint'(pitch_error), 400);
        chk("disarm_i_pitch", longint'(i_pitch_error), 0);
        chk("disarm_d_pitch", longint'(d_pitch_error), 0);

        set_arm(1'b1);
        send(300, 0, 0, 0, 0, 0);
        idle(4);
        chk("rearm_i_pitch", longint'(i_pitch_error), 300);
        chk("rearm_d_pitch", longint'(d_pitch_error), 0);

        // Disarm lands on the ACC edge of a sample already in flight.
        arm_plan = 1'b0;
        send(800, 0, 0, 0, 0, 0);
        idle(1);
        @(negedge clk);
        arm = 1'b0;
        idle(4);
        chk("accdis_pitch", longint'(pitch_error), 800);
        chk("accdis_i_pitch", longint'(i_pitch_error), 0);
        chk("accdis_d_pitch", longint'(d_pitch_error), 0);

        set_arm(1'b1);
        send(0, 0, 0, 0, 17900, -17900);
        idle(4);
        chk("yaw_error", longint'(yaw_error), YAW_WRAP ? -200 : 35800);

        send(1234, 0, 0, 0, 0, 0);
        idle(1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle(6);
        chk("midreset_pitch", longint'(pitch_error), 0);

        idle(3);
        chk("pending_samples", longint'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
